int_vector_mac_sequencer: RTL and testbench
===========================================

# int_vector_mac_sequencer

Controller that runs one multi-chunk dot product on an `int_vector_mac` instance per command. It accepts a command giving the number of `Size`-lane operand chunks, streams the chunks into the MAC, and returns the accumulated result over a valid/ready port. It drives the MAC's clear and operand inputs. Because the MAC accumulates every cycle, the sequencer feeds it zero operands whenever no chunk is being transferred.

## Interface
- `DataWidth`, 8: operand lane width (signed).
- `Size`, 16: lanes per chunk.
- `AccumulatorWidth`, 32: MAC accumulator width.
- `MaxChunks`, 256: largest chunk count per command.
- `OutWidth`, 32: result width; must be ≤ `AccumulatorWidth`.
- `CountWidth`, localparam `$clog2(MaxChunks+1)`.

Ports:
- `clock`  in  1  sole clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `cmd_valid_i` / `cmd_ready_o`  in/out  1  command handshake.
- `cmd_chunks_i`  in  CountWidth  chunks in the dot product.
- `op_valid_i` / `op_ready_o`  in/out  1  operand chunk handshake.
- `op0_vec_i`, `op1_vec_i`  in  Size×DataWidth  signed operand chunk.
- `mac_clear_o`  out  1  to the MAC `reset_i` (synchronous clear).
- `mac_op0_vec_o`, `mac_op1_vec_o`  out  Size×DataWidth  to the MAC operands.
- `mac_acc_i`  in  AccumulatorWidth  from the MAC `mac_o`.
- `res_valid_o` / `res_ready_i`  out/in  1  result handshake.
- `res_data_o`  out  OutWidth  signed result.
- `res_sat_o`  out  1  result was saturated.
- `busy_o`  out  1  state ≠ IDLE.

## Operation
- **IDLE**
  - `cmd_ready_o`=1 and `mac_clear_o`=1; the accumulator is held at 0.
  - On a command handshake, latch the count, clamping values above `MaxChunks` to `MaxChunks`.
  - Count = 0 → DRAIN. Otherwise → STREAM.
- **STREAM**
  - `op_ready_o`=1 and `mac_clear_o`=0.
  - `mac_op*_vec_o` = `op*_vec_i` when `op_valid_i` is high, else all zeros.
  - Each transfer decrements the remaining count. The transfer that brings the count to 0 moves the state to DRAIN.
- **DRAIN** (exactly one cycle)
  - `mac_clear_o`=1; `mac_acc_i` is the final sum.
  - Register the narrowed `mac_acc_i` into `res_data_o` / `res_sat_o`, then → RESULT.
- **RESULT**
  - `res_valid_o`=1 and `mac_clear_o`=1.
  - `res_data_o` and `res_sat_o` are held stable until `res_ready_i` is high, then → IDLE.
  - The next command is accepted in IDLE, never in RESULT.
- **Operand outputs:** `mac_op*_vec_o` are zero in every state except STREAM.
- **Arithmetic:** accumulator overflow wraps inside the MAC and is not detected. Narrowing to `OutWidth` is described under Configuration.
- **Reset values:**
  - State = IDLE, count = 0.
  - `cmd_ready_o`=1, `mac_clear_o`=1.
  - `op_ready_o`=0, `res_valid_o`=0, `busy_o`=0.
  - `res_data_o`=0, `res_sat_o`=0, `mac_op*`=0.

## Timing
- Command accepted at cycle T with N chunks sent back-to-back:
  - Chunks transfer in T+1 … T+N.
  - DRAIN occurs in T+N+1.
  - `res_valid_o` rises in T+N+2.
- N = 0: DRAIN in T+1, `res_valid_o` in T+2 with `res_data_o` = 0.
- `op_valid_i` bubbles stretch STREAM one cycle per bubble; the result is unchanged.
- `op_ready_o` and `cmd_ready_o` are combinational from state only. They do not depend on the matching valid input.
- Asserting `reset_i` in any state forces the reset values immediately, without waiting for `clock`.
  - The in-flight command and any partial sum are discarded.
  - The MAC is cleared on the first clock edge after `reset_i` deasserts.

## Configuration
- `INT_VECTOR_MAC_SEQ_SAT_EN` defined: `res_data_o` is `mac_acc_i` saturated to the signed `OutWidth` range, and `res_sat_o`=1 when clipping occurred.
- Not defined: `res_data_o` is the low `OutWidth` bits of `mac_acc_i` (wrap), and `res_sat_o` is tied to 0.
- With `OutWidth` = `AccumulatorWidth`, both modes are identical.

## Structure
- Package `int_vector_mac_pkg` holds:
  - the state enum `mac_seq_state_e` (IDLE, STREAM, DRAIN, RESULT);
  - the default widths.
- Sub-module `int_vector_mac_narrow`: combinational `AccumulatorWidth` → `OutWidth` conversion that produces `res_data` and `res_sat`. It is the only place the macro is tested.

## Test plan
- **Reset:** assert `reset_i` with the clock stopped → `cmd_ready_o`=1, `mac_clear_o`=1, `res_valid_o`=0, `mac_op*`=0, `busy_o`=0.
- **Two chunks, backpressure:** cmd=2; chunk0 all lanes 1×2, chunk1 all lanes −3×4; `res_ready_i`=0 for 3 cycles → `res_data_o`=−160 from T+4, held stable for 3 cycles, then IDLE.
- **Zero chunks:** cmd=0 → `res_valid_o` at T+2 with `res_data_o`=0; `op_ready_o` never asserted.
- **Bubbles:** cmd=3 with 2-cycle `op_valid_i` bubbles between chunks → `mac_op*`=0 during bubbles; result equals the reference dot product; `res_valid_o` at T+3+4+2.
- **Saturation:** `OutWidth`=16, cmd=2, all lanes 127×127 (sum 516128):
  - with the macro → `res_data_o`=32767, `res_sat_o`=1;
  - without the macro → `res_data_o`=−8160, `res_sat_o`=0.
- **Reset mid-operation:** cmd=3, assert `reset_i` after one chunk → immediate reset values; then cmd=1 with all lanes 2×3 → `res_data_o`=96, unpolluted by the aborted sum.

Source files
------------

// File: rtl/int_vector_mac_pkg.sv
// int_vector_mac_pkg
//   Shared types and default widths for the int_vector_mac sequencer slice.
//   - mac_seq_state_e : sequencer FSM states (IDLE, STREAM, DRAIN, RESULT)
//   - DEF_*           : default parameter values used by the sequencer top
package int_vector_mac_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_SIZE       = 16;
  localparam int DEF_ACC_WIDTH  = 32;
  localparam int DEF_MAX_CHUNKS = 256;
  localparam int DEF_OUT_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    RESULT = 2'd3
  } mac_seq_state_e;

endpackage

// File: rtl/int_vector_mac_narrow.sv
// int_vector_mac_narrow
//   Combinational AccumulatorWidth -> OutWidth conversion of the final MAC sum.
//   Macro INT_VECTOR_MAC_SEQ_SAT_EN:
//     defined   : signed saturation to the OutWidth range, res_sat flags clipping
//     undefined : keep the low OutWidth bits (wrap), res_sat is 0
// Ports:
//   acc_i    in  AccumulatorWidth  signed accumulator value
//   res_data out OutWidth          signed narrowed result
//   res_sat  out 1                 clipping occurred
module int_vector_mac_narrow #(
  parameter int AccumulatorWidth = 32,
  parameter int OutWidth         = 32
) (
  input  logic signed [AccumulatorWidth-1:0] acc_i,
  output logic signed [OutWidth-1:0]         res_data,
  output logic                               res_sat
);

`ifdef INT_VECTOR_MAC_SEQ_SAT_EN
  // Largest/smallest OutWidth-signed values, sign-extended to accumulator width.
  localparam logic signed [AccumulatorWidth-1:0] MaxOut =
    {{(AccumulatorWidth-OutWidth+1){1'b0}}, {(OutWidth-1){1'b1}}};
  localparam logic signed [AccumulatorWidth-1:0] MinOut = ~MaxOut;

  always_comb begin
    res_data = acc_i[OutWidth-1:0];
    res_sat  = 1'b0;
    if (acc_i > MaxOut) begin
      res_data = MaxOut[OutWidth-1:0];
      res_sat  = 1'b1;
    end else if (acc_i < MinOut) begin
      res_data = MinOut[OutWidth-1:0];
      res_sat  = 1'b1;
    end
  end
`else
  // Upper accumulator bits are intentionally dropped in wrap mode.
  logic w_unused_acc;
  assign w_unused_acc = ^acc_i;
  assign res_data     = acc_i[OutWidth-1:0];
  assign res_sat      = 1'b0;
`endif

endmodule

// File: rtl/int_vector_mac_sequencer.sv
// int_vector_mac_sequencer
//   Runs one multi-chunk dot product on an external int_vector_mac per command.
//   Streams operand chunks into the MAC (zeros whenever no chunk transfers,
//   since the MAC accumulates every cycle), then returns the narrowed sum.
//   Narrowing mode selected by macro INT_VECTOR_MAC_SEQ_SAT_EN (see
//   int_vector_mac_narrow).
// Ports:
//   clock, reset_i                 clock, async active-high reset
//   cmd_valid_i/cmd_ready_o        command handshake, cmd_chunks_i = chunk count
//   op_valid_i/op_ready_o          operand chunk handshake, op0/op1_vec_i
//   mac_clear_o, mac_op0/1_vec_o   MAC synchronous clear and operands
//   mac_acc_i                      MAC accumulator
//   res_valid_o/res_ready_i        result handshake, res_data_o / res_sat_o
//   busy_o                         not idle
module int_vector_mac_sequencer
  import int_vector_mac_pkg::*;
#(
  parameter  int DataWidth        = DEF_DATA_WIDTH,
  parameter  int Size             = DEF_SIZE,
  parameter  int AccumulatorWidth = DEF_ACC_WIDTH,
  parameter  int MaxChunks        = DEF_MAX_CHUNKS,
  parameter  int OutWidth         = DEF_OUT_WIDTH,
  localparam int CountWidth       = $clog2(MaxChunks + 1)
) (
  input  logic                               clock,
  input  logic                               reset_i,
  input  logic                               cmd_valid_i,
  output logic                               cmd_ready_o,
  input  logic [CountWidth-1:0]              cmd_chunks_i,
  input  logic                               op_valid_i,
  output logic                               op_ready_o,
  input  logic [Size-1:0][DataWidth-1:0]     op0_vec_i,
  input  logic [Size-1:0][DataWidth-1:0]     op1_vec_i,
  output logic                               mac_clear_o,
  output logic [Size-1:0][DataWidth-1:0]     mac_op0_vec_o,
  output logic [Size-1:0][DataWidth-1:0]     mac_op1_vec_o,
  input  logic signed [AccumulatorWidth-1:0] mac_acc_i,
  output logic                               res_valid_o,
  input  logic                               res_ready_i,
  output logic signed [OutWidth-1:0]         res_data_o,
  output logic                               res_sat_o,
  output logic                               busy_o
);

  localparam logic [CountWidth-1:0] MaxCount = CountWidth'(MaxChunks);
  localparam logic [CountWidth-1:0] OneCount = CountWidth'(1);

  mac_seq_state_e               r_state, w_state_nxt;
  logic [CountWidth-1:0]        r_count, w_cmd_count;
  logic signed [OutWidth-1:0]   r_res_data, w_narrow_data;
  logic                         r_res_sat, w_narrow_sat;

  assign w_cmd_count = (cmd_chunks_i > MaxCount) ? MaxCount : cmd_chunks_i;

  int_vector_mac_narrow #(
    .AccumulatorWidth(AccumulatorWidth),
    .OutWidth        (OutWidth)
  ) u_narrow (
    .acc_i   (mac_acc_i),
    .res_data(w_narrow_data),
    .res_sat (w_narrow_sat)
  );

  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Handshake readies depend on state only; the MAC is held cleared outside STREAM.
  always_comb begin
    w_state_nxt   = r_state;
    cmd_ready_o   = 1'b0;
    op_ready_o    = 1'b0;
    mac_clear_o   = 1'b1;
    res_valid_o   = 1'b0;
    busy_o        = 1'b1;
    mac_op0_vec_o = '0;
    mac_op1_vec_o = '0;
    case (r_state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cmd_valid_i) w_state_nxt = (w_cmd_count == '0) ? DRAIN : STREAM;
      end
      STREAM: begin
        op_ready_o  = 1'b1;
        mac_clear_o = 1'b0;
        if (op_valid_i) begin
          mac_op0_vec_o = op0_vec_i;
          mac_op1_vec_o = op1_vec_i;
          if (r_count == OneCount) w_state_nxt = DRAIN;
        end
      end
      DRAIN:   w_state_nxt = RESULT;
      RESULT: begin
        res_valid_o = 1'b1;
        if (res_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // In DRAIN the MAC output already holds the last chunk's contribution.
  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) begin
      r_count    <= '0;
      r_res_data <= '0;
      r_res_sat  <= 1'b0;
    end else begin
      case (r_state)
        IDLE:   if (cmd_valid_i) r_count <= w_cmd_count;
        STREAM: if (op_valid_i)  r_count <= r_count - OneCount;
        DRAIN: begin
          r_res_data <= w_narrow_data;
          r_res_sat  <= w_narrow_sat;
        end
        default: ;
      endcase
    end
  end

  assign res_data_o = r_res_data;
  assign res_sat_o  = r_res_sat;

endmodule

// File: tb/tb_int_vector_mac_sequencer.sv
// tb_int_vector_mac_sequencer
//   Directed bench for int_vector_mac_sequencer (OutWidth = 16 so the
//   narrowing path is exercised). A behavioural MAC closes the loop; a
//   result queue holds the expected dot products computed from the chunk
//   data, and a negedge compare process checks outputs every cycle.
//   Expected narrowing follows INT_VECTOR_MAC_SEQ_SAT_EN if defined.
module tb_int_vector_mac_sequencer;

  localparam int DW = 8, SZ = 16, AW = 32, MC = 256, OW = 16;
  localparam int CW = $clog2(MC + 1);

  typedef logic [SZ-1:0][DW-1:0] vec_t;
  typedef struct { int data; int sat; } res_t;

  logic                 clock = 1'b0, clk_en = 1'b0;
  logic                 reset_i = 1'b0;
  logic                 cmd_valid_i = 1'b0, cmd_ready_o;
  logic [CW-1:0]        cmd_chunks_i = '0;
  logic                 op_valid_i = 1'b0, op_ready_o;
  vec_t                 op0_vec_i = '0, op1_vec_i = '0;
  logic                 mac_clear_o;
  vec_t                 mac_op0_vec_o, mac_op1_vec_o;
  logic signed [AW-1:0] mac_acc = '0;
  logic                 res_valid_o, res_ready_i = 1'b0;
  logic signed [OW-1:0] res_data_o;
  logic                 res_sat_o, busy_o;

  int   n_tests = 0, n_fail = 0;
  res_t exp_q[$];
  vec_t ch0q[$], ch1q[$];

  always #5 if (clk_en) clock = ~clock;

  int_vector_mac_sequencer #(
    .DataWidth(DW), .Size(SZ), .AccumulatorWidth(AW), .MaxChunks(MC), .OutWidth(OW)
  ) dut (
    .clock(clock), .reset_i(reset_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_chunks_i(cmd_chunks_i),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .op0_vec_i(op0_vec_i), .op1_vec_i(op1_vec_i),
    .mac_clear_o(mac_clear_o), .mac_op0_vec_o(mac_op0_vec_o), .mac_op1_vec_o(mac_op1_vec_o),
    .mac_acc_i(mac_acc),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_sat_o(res_sat_o), .busy_o(busy_o)
  );

  function automatic int dot(input vec_t a, input vec_t b);
    int s = 0;
    for (int l = 0; l < SZ; l++) s += int'($signed(a[l])) * int'($signed(b[l]));
    return s;
  endfunction

  function automatic vec_t splat(input logic [DW-1:0] v);
    vec_t r;
    for (int l = 0; l < SZ; l++) r[l] = v;
    return r;
  endfunction

  function automatic res_t model_narrow(input int s);
    res_t r;
    logic [31:0] v;
    v = s;
`ifdef INT_VECTOR_MAC_SEQ_SAT_EN
    if (s > 32767)       begin r.data = 32767;  r.sat = 1; end
    else if (s < -32768) begin r.data = -32768; r.sat = 1; end
    else                 begin r.data = s;      r.sat = 0; end
`else
    r.data = int'($signed(v[15:0]));
    r.sat  = 0;
`endif
    return r;
  endfunction

  // Behavioural MAC: synchronous clear, otherwise accumulates each cycle.
  always @(posedge clock) begin
    if (mac_clear_o) mac_acc <= '0;
    else             mac_acc <= mac_acc + dot(mac_op0_vec_o, mac_op1_vec_o);
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string nm, input vec_t act, input vec_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clock) begin
    if (!reset_i) begin
      chk_vec("mac_op0", mac_op0_vec_o, (op_ready_o && op_valid_i) ? op0_vec_i : '0);
      chk_vec("mac_op1", mac_op1_vec_o, (op_ready_o && op_valid_i) ? op1_vec_i : '0);
      chk("busy_vs_idle", busy_o, !cmd_ready_o);
      chk("clear_vs_stream", mac_clear_o, !op_ready_o);
      if (res_valid_o) begin
        chk("res_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("res_data", res_data_o, exp_q[0].data);
          chk("res_sat", res_sat_o, exp_q[0].sat);
          if (res_ready_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  // One command: n chunks from ch0q/ch1q, bub bubble cycles after each chunk,
  // result held rdy_wait cycles before acceptance. Latency/data literals pin the model.
  task automatic run(input int n, input int bub, input int rdy_wait, input int exp_lat,
                     input int exp_data, input int exp_sat);
    logic acc = 1'b0, seen = 1'b0, taken, any_opr = 1'b0;
    int   lat = 0, idx = 0, gap = 0, sum = 0;
    vec_t junk = splat(8'hA5);
    cmd_chunks_i = CW'(n);
    cmd_valid_i  = 1'b1;
    op_valid_i   = 1'b0;
    for (int w = 0; w < 50 && !acc; w++) begin
      @(negedge clock); acc = cmd_ready_o;
      @(posedge clock); #1;
    end
    chk("cmd_accept", acc, 1);
    cmd_valid_i = 1'b0;
    for (int k = 0; k < n; k++) sum += dot(ch0q[k], ch1q[k]);
    exp_q.push_back(model_narrow(sum));
    for (int c = 1; c <= 300 && !seen; c++) begin
      if (idx < n && gap == 0) begin
        op_valid_i = 1'b1; op0_vec_i = ch0q[idx]; op1_vec_i = ch1q[idx];
      end else begin
        // bubbles drive invalid junk; after the last chunk junk is marked valid
        op_valid_i = (idx >= n); op0_vec_i = junk; op1_vec_i = ~junk;
      end
      @(negedge clock);
      taken   = op_valid_i && op_ready_o;
      any_opr = any_opr | op_ready_o;
      if (res_valid_o) begin seen = 1'b1; lat = c; end
      @(posedge clock); #1;
      if (taken) begin idx++; gap = bub; end
      else if (gap > 0) gap--;
    end
    op_valid_i = 1'b0;
    chk("res_latency", lat, exp_lat);
    chk("chunks_taken", idx, n);
    if (n == 0) chk("op_ready_never", any_opr, 0);
    chk("res_data_lit", res_data_o, exp_data);
    chk("res_sat_lit", res_sat_o, exp_sat);
    repeat (rdy_wait - 1) begin
      @(negedge clock); chk("res_hold_valid", res_valid_o, 1);
      @(posedge clock); #1;
    end
    res_ready_i = 1'b1;
    @(negedge clock);
    @(posedge clock); #1;
    res_ready_i = 1'b0;
    @(negedge clock);
    chk("back_idle_cmd_ready", cmd_ready_o, 1);
    chk("back_idle_res_valid", res_valid_o, 0);
    ch0q.delete(); ch1q.delete();
    @(posedge clock); #1;
  endtask

  initial begin
    // Reset with the clock stopped.
    #2 reset_i = 1'b1;
    #1;
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_mac_clear", mac_clear_o, 1);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_op_ready", op_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_mac_op", |{mac_op0_vec_o, mac_op1_vec_o}, 0);
    chk("rst_res_data", res_data_o, 0);
    chk("rst_res_sat", res_sat_o, 0);
    #1 clk_en = 1'b1;
    @(posedge clock); @(posedge clock); #1 reset_i = 1'b0;

    // Two chunks with result backpressure: 16*(1*2) + 16*(-3*4) = -160.
    ch0q.push_back(splat(8'd1));  ch1q.push_back(splat(8'd2));
    ch0q.push_back(splat(8'hFD)); ch1q.push_back(splat(8'd4));
    run(2, 0, 3, 4, -160, 0);

    // Zero chunks.
    run(0, 0, 1, 2, 0, 0);

    // Bubbles: lane l of op0 = l-8, op1 = k+1 -> (1+2+3) * -8 = -48.
    for (int k = 0; k < 3; k++) begin
      vec_t a, b;
      for (int l = 0; l < SZ; l++) begin a[l] = 8'(l - 8); b[l] = 8'(k + 1); end
      ch0q.push_back(a); ch1q.push_back(b);
    end
    run(3, 2, 2, 9, -48, 0);

    // Saturation: 2 * 16 * 127*127 = 516128.
    ch0q.push_back(splat(8'd127)); ch1q.push_back(splat(8'd127));
    ch0q.push_back(splat(8'd127)); ch1q.push_back(splat(8'd127));
`ifdef INT_VECTOR_MAC_SEQ_SAT_EN
    run(2, 0, 1, 4, 32767, 1);
`else
    run(2, 0, 1, 4, -8160, 0);
`endif

    // Reset in the middle of STREAM after one chunk.
    cmd_chunks_i = CW'(3);
    cmd_valid_i  = 1'b1;
    @(negedge clock); chk("mid_cmd_ready", cmd_ready_o, 1);
    @(posedge clock); #1;
    cmd_valid_i = 1'b0;
    op_valid_i  = 1'b1; op0_vec_i = splat(8'd5); op1_vec_i = splat(8'd7);
    @(posedge clock); #2;
    reset_i = 1'b1;
    #1;
    chk("mid_rst_cmd_ready", cmd_ready_o, 1);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_op_ready", op_ready_o, 0);
    chk("mid_rst_mac_clear", mac_clear_o, 1);
    chk("mid_rst_res_valid", res_valid_o, 0);
    chk("mid_rst_mac_op", |{mac_op0_vec_o, mac_op1_vec_o}, 0);
    exp_q.delete();
    op_valid_i = 1'b0;
    @(posedge clock); #1 reset_i = 1'b0;

    // Fresh command after abort: 16 * 2*3 = 96.
    ch0q.push_back(splat(8'd2)); ch1q.push_back(splat(8'd3));
    run(1, 0, 1, 3, 96, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
